rx_tlp_sched_mc: RTL and testbench

- Multi-channel successor to the single-channel RX TLP trigger controller; lives in the pcie_clk domain between N per-channel prod_sync outputs and a shared buff2tlp-class DMA engine.
- Per channel: compares synchronised committed producer pointer against an internal issue pointer, then requests either a full max-payload TLP or a timed-out partial flush.
- Round-robin arbitration across channels.
- Request/ack handshake replaces the trig_tlp/send_qws pair.

---
 rtl/rx_sched_pkg.sv | 32 +++
 rtl/rx_rr_arb.sv | 38 +++
 rtl/rx_tlp_sched_mc.sv | 221 ++++++++++++++++++++++
 tb/tb_rx_tlp_sched_mc.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_sched_pkg.sv
// ----------------------------------------------------------------------------
// rx_sched_pkg
// Shared definitions for the multi-channel RX TLP scheduler:
//   - PCIe max-payload-size encodings
//   - scheduler FSM state type
//   - mps2qw(): MPS encoding -> QW count, capped to the request width
// ----------------------------------------------------------------------------
package rx_sched_pkg;

    localparam logic [2:0] MPS_128B  = 3'd0;
    localparam logic [2:0] MPS_256B  = 3'd1;
    localparam logic [2:0] MPS_512B  = 3'd2;
    localparam logic [2:0] MPS_1024B = 3'd3;
    localparam logic [2:0] MPS_2048B = 3'd4;
    localparam logic [2:0] MPS_4096B = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } sched_state_e;

    // 128 B = 16 QWs; each encoding step doubles. The request field can only
    // carry up to 2**(qwcw-1) QWs, so larger payloads are capped there.
    function automatic int unsigned mps2qw(input logic [2:0] mps, input int unsigned qwcw);
        int unsigned qw;
        int unsigned cap;
        qw  = 32'd16 << mps;
        cap = 32'd1 << (qwcw - 1);
        return (qw > cap) ? cap : qw;
    endfunction

endpackage

// File: rtl/rx_rr_arb.sv
// ----------------------------------------------------------------------------
// rx_rr_arb
// Combinational round-robin pick: returns the first eligible channel at or
// after rr_ptr_i, wrapping modulo NCH.
// Ports:
//   elig_i      in  NCH  per-channel eligible flags
//   rr_ptr_i    in  CW   channel with highest priority this pick
//   grant_o     out CW   chosen channel (0 when nothing is eligible)
//   any_valid_o out 1    at least one channel eligible
// ----------------------------------------------------------------------------
module rx_rr_arb #(
    parameter int NCH = 2,
    parameter int CW  = 1
) (
    input  logic [NCH-1:0] elig_i,
    input  logic [CW-1:0]  rr_ptr_i,
    output logic [CW-1:0]  grant_o,
    output logic           any_valid_o
);

    always_comb begin
        logic          found;
        logic [CW-1:0] idx;
        grant_o     = '0;
        any_valid_o = 1'b0;
        found       = 1'b0;
        idx         = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = CW'((int'(rr_ptr_i) + k) % NCH);
            if (!found && elig_i[idx]) begin
                grant_o = idx;
                found   = 1'b1;
            end
        end
        any_valid_o = found;
    end

endmodule

// File: rtl/rx_tlp_sched_mc.sv
// ----------------------------------------------------------------------------
// rx_tlp_sched_mc
// Multi-channel RX TLP request scheduler (pcie_clk domain). For each channel
// the committed producer pointer is compared with an internal issue pointer;
// a full max-payload request is raised when enough QWs are available, or a
// partial flush once the channel has sat with a short remainder for TOUT
// cycles. Channels are served round-robin through a req/ack handshake.
//
// States:
//   IDLE | no request outstanding; arbitrate eligible channels
//   REQ  | request presented, outputs frozen until req_ack
//
// Ports:
//   clk                   in   pcie clock
//   rst_n                 in   async active-low reset (deassert synchronised)
//   cfg_max_payload_size  in   PCIe MPS encoding
//   committed_prod        in   per-channel producer pointer, ch i at [i*BW +: BW]
//   ch_en                 in   per-channel host buffer ready
//   req                   out  request valid
//   req_ch                out  granted channel
//   req_qws               out  QWs to send
//   req_full              out  1 = full MPS TLP, 0 = partial flush
//   req_ack               in   DMA accepted request (ignored while req=0)
//   iss_ptr               out  per-channel issue pointer
//   stat_full / stat_part out  per-channel acked full/partial counts
//                              (only when RX_SCHED_STATS_EN is defined)
// ----------------------------------------------------------------------------
module rx_tlp_sched_mc
    import rx_sched_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int BW   = 10,
    parameter int QWCW = 6,
    parameter int TW   = 9,
    parameter int TOUT = 256,
    parameter int CW   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        cfg_max_payload_size,
    input  logic [NCH*BW-1:0] committed_prod,
    input  logic [NCH-1:0]    ch_en,
    output logic              req,
    output logic [CW-1:0]     req_ch,
    output logic [QWCW-1:0]   req_qws,
    output logic              req_full,
    input  logic              req_ack,
    output logic [NCH*BW-1:0] iss_ptr
`ifdef RX_SCHED_STATS_EN
    ,
    output logic [NCH*32-1:0] stat_full,
    output logic [NCH*32-1:0] stat_part
`endif
);

    localparam logic [TW-1:0] TOUT_T = TW'(TOUT);

    // Assert follows rst_n immediately; release is aligned to clk.
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    sched_state_e                state_q, state_d;
    logic [CW-1:0]               rr_q, rr_d;
    logic                        req_q, req_d;
    logic [CW-1:0]               req_ch_q, req_ch_d;
    logic [QWCW-1:0]             req_qws_q, req_qws_d;
    logic                        req_full_q, req_full_d;
    logic [NCH-1:0][BW-1:0]      iss_q, iss_d;
    logic [NCH-1:0][TW-1:0]      timer_q, timer_d;

    logic [QWCW-1:0]             mps_qw;
    logic [BW-1:0]               mps_bw;
    logic [NCH-1:0][BW-1:0]      avail;
    logic [NCH-1:0]              full_ok;
    logic [NCH-1:0]              part_win;
    logic [NCH-1:0]              elig;
    logic [CW-1:0]               grant;
    logic                        any_valid;
    logic                        ack_fire;

    assign mps_qw   = QWCW'(mps2qw(cfg_max_payload_size, QWCW));
    assign mps_bw   = BW'(mps_qw);
    assign ack_fire = (state_q == REQ) && req_ack;

    // Modular subtraction keeps avail correct across pointer wrap.
    always_comb begin
        avail    = '0;
        full_ok  = '0;
        part_win = '0;
        elig     = '0;
        for (int i = 0; i < NCH; i++) begin
            avail[i]    = committed_prod[i*BW +: BW] - iss_q[i];
            full_ok[i]  = (avail[i] >= mps_bw);
            part_win[i] = (avail[i] != '0) && !full_ok[i];
            elig[i]     = ch_en[i] && (full_ok[i] || (part_win[i] && (timer_q[i] == TOUT_T)));
        end
    end

    rx_rr_arb #(
        .NCH (NCH),
        .CW  (CW)
    ) u_rr_arb (
        .elig_i      (elig),
        .rr_ptr_i    (rr_q),
        .grant_o     (grant),
        .any_valid_o (any_valid)
    );

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        req_d      = req_q;
        req_ch_d   = req_ch_q;
        req_qws_d  = req_qws_q;
        req_full_d = req_full_q;
        iss_d      = iss_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_d      = 1'b1;
                    req_ch_d   = grant;
                    req_full_d = full_ok[grant];
                    // A partial remainder is always below mps_qw, so it fits QWCW.
                    req_qws_d  = full_ok[grant] ? mps_qw : QWCW'(avail[grant]);
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (req_ack) begin
                    req_d           = 1'b0;
                    iss_d[req_ch_q] = iss_q[req_ch_q] + BW'(req_qws_q);
                    rr_d            = (req_ch_q == CW'(NCH - 1)) ? '0 : req_ch_q + 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        for (int i = 0; i < NCH; i++) begin
            if (ack_fire && (req_ch_q == CW'(i))) begin
                timer_d[i] = '0;
            end else if (ch_en[i] && part_win[i]) begin
                timer_d[i] = (timer_q[i] == TOUT_T) ? TOUT_T : timer_q[i] + 1'b1;
            end else begin
                timer_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            req_q      <= 1'b0;
            req_ch_q   <= '0;
            req_qws_q  <= '0;
            req_full_q <= 1'b0;
            iss_q      <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            req_q      <= req_d;
            req_ch_q   <= req_ch_d;
            req_qws_q  <= req_qws_d;
            req_full_q <= req_full_d;
            iss_q      <= iss_d;
            timer_q    <= timer_d;
        end
    end

    assign req      = req_q;
    assign req_ch   = req_ch_q;
    assign req_qws  = req_qws_q;
    assign req_full = req_full_q;
    assign iss_ptr  = iss_q;

`ifdef RX_SCHED_STATS_EN
    logic [NCH-1:0][31:0] stat_full_q, stat_full_d;
    logic [NCH-1:0][31:0] stat_part_q, stat_part_d;

    always_comb begin
        stat_full_d = stat_full_q;
        stat_part_d = stat_part_q;
        if (ack_fire) begin
            if (req_full_q) begin
                stat_full_d[req_ch_q] = stat_full_q[req_ch_q] + 32'd1;
            end else begin
                stat_part_d[req_ch_q] = stat_part_q[req_ch_q] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            stat_full_q <= '0;
            stat_part_q <= '0;
        end else begin
            stat_full_q <= stat_full_d;
            stat_part_q <= stat_part_d;
        end
    end

    assign stat_full = stat_full_q;
    assign stat_part = stat_part_q;
`endif

endmodule

// File: tb/tb_rx_tlp_sched_mc.sv
// ----------------------------------------------------------------------------
// tb_rx_tlp_sched_mc
// Scoreboard bench for rx_tlp_sched_mc: each scenario pushes the requests it
// expects, and serve() pops and compares them as the DUT raises req, then
// acks and checks the issue pointer against the bench's own pointer model.
// Stats ports are connected when RX_SCHED_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_rx_tlp_sched_mc;

    localparam int NCH  = 2;
    localparam int BW   = 10;
    localparam int QWCW = 6;
    localparam int TW   = 9;
    localparam int TOUT = 256;
    localparam int CW   = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        cfg_max_payload_size = 3'd0;
    logic [NCH*BW-1:0] committed_prod = '0;
    logic [NCH-1:0]    ch_en = '1;
    logic              req;
    logic [CW-1:0]     req_ch;
    logic [QWCW-1:0]   req_qws;
    logic              req_full;
    logic              req_ack = 1'b0;
    logic [NCH*BW-1:0] iss_ptr;
`ifdef RX_SCHED_STATS_EN
    logic [NCH*32-1:0] stat_full;
    logic [NCH*32-1:0] stat_part;
`endif

    rx_tlp_sched_mc #(
        .NCH (NCH), .BW (BW), .QWCW (QWCW), .TW (TW), .TOUT (TOUT), .CW (CW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cfg_max_payload_size (cfg_max_payload_size),
        .committed_prod       (committed_prod),
        .ch_en                (ch_en),
        .req                  (req),
        .req_ch               (req_ch),
        .req_qws              (req_qws),
        .req_full             (req_full),
        .req_ack              (req_ack),
        .iss_ptr              (iss_ptr)
`ifdef RX_SCHED_STATS_EN
        ,
        .stat_full            (stat_full),
        .stat_part            (stat_part)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int qws;
        int full;
    } exp_t;

    exp_t exp_q[$];
    int   iss_m[NCH];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int ch, input int qws, input int full);
        exp_t e;
        e.ch = ch;
        e.qws = qws;
        e.full = full;
        exp_q.push_back(e);
    endtask

    task automatic set_prod(input int ch, input int val);
        committed_prod[ch*BW +: BW] = BW'(val);
    endtask

    // Wait (bounded) for req, compare with the scoreboard head, hold ack low
    // for 'hold' cycles checking the outputs stay frozen (optionally changing
    // MPS at cycle chg_at), then ack and check the issue pointer.
    task automatic serve(input int bound, input int hold, input int chg_at, input logic [2:0] chg_val);
        exp_t          e;
        int            n;
        int            unstable;
        logic [CW-1:0] ch0;
        logic [QWCW-1:0] q0;
        logic          f0;
        n = 0;
        while (!req && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!req) begin
            chk("req_timeout", 0, 1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            chk("unexpected_req", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("req_ch", 64'(req_ch), 64'(e.ch));
        chk("req_qws", 64'(req_qws), 64'(e.qws));
        chk("req_full", 64'(req_full), 64'(e.full));
        ch0 = req_ch;
        q0 = req_qws;
        f0 = req_full;
        unstable = 0;
        for (int k = 0; k < hold; k++) begin
            if (k == chg_at) cfg_max_payload_size = chg_val;
            @(negedge clk);
            if (req !== 1'b1 || req_ch !== ch0 || req_qws !== q0 || req_full !== f0) unstable++;
        end
        if (hold > 0) chk("hold_stable", 64'(unstable), 0);
        req_ack = 1'b1;
        @(negedge clk);
        req_ack = 1'b0;
        iss_m[e.ch] = (iss_m[e.ch] + e.qws) % (1 << BW);
        chk("req_drop", 64'(req), 0);
        chk("iss_ptr", 64'(iss_ptr[e.ch*BW +: BW]), 64'(iss_m[e.ch]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < NCH; i++) iss_m[i] = 0;
        chk("rst_req", 64'(req), 0);
        chk("rst_req_ch", 64'(req_ch), 0);
        chk("rst_req_qws", 64'(req_qws), 0);
        chk("rst_req_full", 64'(req_full), 0);
        chk("rst_iss", 64'(iss_ptr), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;

        // T1: two full requests, then a timed-out partial flush.
        do_reset();
        set_prod(0, 40);
        push_exp(0, 16, 1);
        push_exp(0, 16, 1);
        serve(20, 0, -1, 3'd0);
        serve(20, 0, -1, 3'd0);
        bad = 0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (req) bad++;
        end
        chk("t1_no_early_partial", 64'(bad), 0);
        push_exp(0, 8, 0);
        serve(30, 0, -1, 3'd0);

        // T2: simultaneous channels, round-robin alternation.
        set_prod(0, 0);
        do_reset();
        set_prod(0, 32);
        set_prod(1, 32);
        push_exp(0, 16, 1);
        push_exp(1, 16, 1);
        push_exp(0, 16, 1);
        push_exp(1, 16, 1);
        for (int k = 0; k < 4; k++) serve(10, 0, -1, 3'd0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req) bad++;
        end
        chk("t2_no_extra_req", 64'(bad), 0);

        // T3: bring iss_ptr[1] to 1016, then producer wraps to 8.
        set_prod(0, 0);
        set_prod(1, 0);
        do_reset();
        set_prod(1, 1016);
        for (int k = 0; k < 63; k++) push_exp(1, 16, 1);
        push_exp(1, 8, 0);
        for (int k = 0; k < 63; k++) serve(10, 0, -1, 3'd0);
        serve(300, 0, -1, 3'd0);
        set_prod(1, 8);
        push_exp(1, 16, 1);
        serve(10, 0, -1, 3'd0);

        // T4: disabled channel with avail=20 stays quiet, timer held at 0.
        ch_en = 2'b01;
        set_prod(1, 28);
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (req || dut.timer_q[1] != '0) bad++;
        end
        chk("t4_disabled_quiet", 64'(bad), 0);
        ch_en = 2'b11;
        push_exp(1, 16, 1);
        serve(10, 0, -1, 3'd0);

        // T5: MPS change while a request is held; next request uses 32.
        set_prod(1, 0);
        do_reset();
        set_prod(0, 64);
        push_exp(0, 16, 1);
        serve(10, 50, 10, 3'd1);
        push_exp(0, 32, 1);
        serve(10, 0, -1, 3'd0);
`ifdef RX_SCHED_STATS_EN
        chk("t5_stat_full0", 64'(stat_full[31:0]), 2);
        chk("t5_stat_part0", 64'(stat_part[31:0]), 0);
`endif

        // T6: async reset while a request is pending.
        set_prod(0, 112);
        bad = 0;
        while (!req && bad < 10) begin
            @(negedge clk);
            bad++;
        end
        chk("t6_req_pending", 64'(req), 1);
        chk("t6_req_qws", 64'(req_qws), 32);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_req", 64'(req), 0);
        chk("t6_async_iss", 64'(iss_ptr), 0);
        chk("t6_async_qws", 64'(req_qws), 0);
`ifdef RX_SCHED_STATS_EN
        chk("t6_stat_full", 64'(stat_full), 0);
        chk("t6_stat_part", 64'(stat_part), 0);
`endif
        set_prod(0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
